instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle fetch/decode/execute controller for the 16-bit processor. It requests instruction words from ROM and fetches RAM operands when an instruction needs one. Once per retired instruction it issues a single `pc_enable` pulse to the program counter, together with the execute strobe for the ALU/register file. It also provides run/step/halt debug control, wait-state handshakes and a stall-timeout fault.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of opcode, operand and RAM data.
- `WAIT_LIMIT`, 255, maximum cycles spent waiting for `rom_valid` or `ram_ack` before a fault is raised (1..65535).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `run`  in  1  level; while high and not halting, instructions issue back-to-back.
- `step`  in  1  one-cycle pulse; when halted, execute exactly one instruction.
- `halt_req`  in  1  level; stop at the next instruction boundary.
- `rom_data`  in  2*DATA_WIDTH  `{opcode, operand}` word at the current PC.
- `rom_valid`  in  1  `rom_data` valid (handshake with `rom_req`).
- `rom_req`  out  1  instruction fetch request.
- `pc_read_enable`  out  1  PC drives the shared address bus (high during FETCH).
- `ram_req`  out  1  operand read request; `ram_addr` is stable while high.
- `ram_addr`  out  DATA_WIDTH  equals latched operand.
- `ram_ack`  in  1  RAM data valid this cycle.
- `ram_data`  in  DATA_WIDTH  RAM read data.
- `opcode`, `operand`, `mem_data`  out  DATA_WIDTH each  latched instruction fields and RAM operand, held until the next fetch/read completes.
- `pc_enable`  out  1  one-cycle pulse per retired instruction.
- `exec_enable`  out  1  one-cycle pulse coincident with `pc_enable`.
- `halted`, `fault`  out  1  status.
- `instr_count`  out  16  retired instruction counter.

## Operation
- States: HALTED, FETCH, DECODE, MEM, EXEC, FAULT.
- HALTED: `halted`=1.
  - `run`=1 and `halt_req`=0 → FETCH.
  - Else a `step` pulse → FETCH with the single-step flag set.
  - `step` outside HALTED is ignored.
- FETCH: `rom_req`=1, `pc_read_enable`=1. On `rom_valid`, latch `opcode`/`operand` → DECODE.
- DECODE (1 cycle):
  - `opcode` == HALT_OPCODE (16'hFFFF) → HALTED, with no `pc_enable` and no count.
  - `opcode[15:12]` in RAM-source set {4'h3 ALU-from-RAM, 4'h7 PC-jump-from-RAM} → MEM.
  - Otherwise → EXEC.
- MEM: `ram_req`=1. On `ram_ack`, latch `mem_data` → EXEC.
- EXEC (1 cycle): `pc_enable`=`exec_enable`=1, `instr_count`+1 (wraps 16'hFFFF→0).
  - Next state is HALTED if `halt_req`, the single-step flag, or `run`=0; otherwise FETCH.
  - The single-step flag clears here.
- Wait timer: counts cycles in FETCH/MEM and clears on state entry. Reaching `WAIT_LIMIT` without the handshake → FAULT.
- FAULT: `fault`=1 and all request/strobe outputs 0. Exit only via reset.
- `halt_req` never aborts FETCH/MEM/DECODE; it is honored only at EXEC exit or while in HALTED.
- `halt_req` has priority over `run` and `step`.

## Timing
- Reset values: state HALTED, `halted`=1, `fault`=0, all req/enable outputs 0, `opcode`/`operand`/`mem_data`/`instr_count`=0, step flag 0, wait timer 0.
- Reset asserted mid-MEM/FETCH: requests drop at that edge and the handshake is abandoned.
- Handshakes:
  - `rom_valid`/`ram_ack` are sampled only while the matching request is high; asserted in the first request cycle, they are accepted that cycle.
  - Late acks in other states are ignored.
- Latency with zero wait states:
  - Non-RAM instruction: 3 cycles (FETCH, DECODE, EXEC).
  - RAM-source instruction: 4 cycles.
  - Each wait state adds 1.
- Issue rate: with `run` held, `pc_enable` pulses every 3 cycles (non-RAM, zero wait). The PC increments on the edge ending EXEC, so the next FETCH sees the new PC.
- Timeout: entering FAULT takes exactly `WAIT_LIMIT` cycles in FETCH/MEM without the handshake. A handshake arriving on cycle `WAIT_LIMIT` loses to the fault.

## Structure
- Shared package `cpu_pkg`:
  - `DATA_WIDTH`, opcode field slices (`[15:12]` select, `[11:8]` operation).
  - `PC_RAM_OP`=4'h7, `PC_ROM_OP`=4'hF, `ALU_RAM_OP`=4'h3, `HALT_OPCODE`=16'hFFFF.
  - Sequencer state enum.
- One sub-module: `seq_wait_timer` (clear, enable, `WAIT_LIMIT` compare, `expired` output).
- FSM, latches and counter live in `instr_sequencer`.

## Test plan
- Reset, then `run`=1, ROM returns 16'h1000/16'h0005 with `rom_valid` immediate → `pc_enable` pulses at cycles 3, 6, 9; `instr_count`=3 after 9 cycles.
- Opcode 16'h7000, operand 16'h0040, `ram_ack` after 2 wait cycles, `ram_data`=16'h1234 → `ram_addr`=16'h0040 while `ram_req`=1, `mem_data`=16'h1234, `pc_enable` at cycle 6.
- Halted, single `step` pulse → exactly one `pc_enable`, returns to HALTED, `instr_count`=1; a `step` during EXEC is ignored.
- `halt_req` raised in mid-FETCH with 3 wait states → instruction completes, one `pc_enable`, then `halted`=1. Opcode 16'hFFFF → HALTED with no `pc_enable`.
- `WAIT_LIMIT`=4, `rom_valid` held low → `fault`=1 on the 4th FETCH cycle, `rom_req`=0. `run` toggling has no effect; `reset` restores HALTED.
- `reset` asserted in MEM → next cycle `ram_req`=0, `halted`=1, `instr_count`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit processor: opcode field helpers,
// RAM-source opcode classes and the instruction sequencer state encoding.
package cpu_pkg;

    localparam int DATA_WIDTH = 16;

    localparam logic [3:0]  PC_RAM_OP   = 4'h7;
    localparam logic [3:0]  PC_ROM_OP   = 4'hF;
    localparam logic [3:0]  ALU_RAM_OP  = 4'h3;
    localparam logic [15:0] HALT_OPCODE = 16'hFFFF;

    typedef enum logic [2:0] {
        S_HALTED = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_EXEC   = 3'd4,
        S_FAULT  = 3'd5
    } seq_state_t;

    function automatic logic [3:0] op_select(input logic [15:0] op);
        return op[15:12];
    endfunction

    function automatic logic [3:0] op_operation(input logic [15:0] op);
        return op[11:8];
    endfunction

    // Instructions whose source operand lives in RAM need an extra MEM phase.
    function automatic logic op_needs_ram(input logic [15:0] op);
        return (op_select(op) == ALU_RAM_OP) || (op_select(op) == PC_RAM_OP);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Counts cycles spent waiting on a handshake; expired goes high on the
// WAIT_LIMIT-th consecutive enabled cycle so that cycle's handshake loses.
module seq_wait_timer #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [15:0] LAST_COUNT = 16'(WAIT_LIMIT - 1);

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= 16'd0;
        end else if (i_enable) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_expired = i_enable && (r_count == LAST_COUNT);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: fetches {opcode, operand} from ROM, reads a
// RAM operand when needed, and pulses pc_enable/exec_enable once per instruction.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int WAIT_LIMIT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    step,
    input  logic                    halt_req,
    input  logic [2*DATA_WIDTH-1:0] rom_data,
    input  logic                    rom_valid,
    output logic                    rom_req,
    output logic                    pc_read_enable,
    output logic                    ram_req,
    output logic [DATA_WIDTH-1:0]   ram_addr,
    input  logic                    ram_ack,
    input  logic [DATA_WIDTH-1:0]   ram_data,
    output logic [DATA_WIDTH-1:0]   opcode,
    output logic [DATA_WIDTH-1:0]   operand,
    output logic [DATA_WIDTH-1:0]   mem_data,
    output logic                    pc_enable,
    output logic                    exec_enable,
    output logic                    halted,
    output logic                    fault,
    output logic [15:0]             instr_count,
    output seq_state_t              dbg_state
);

    seq_state_t r_state;
    seq_state_t w_next_state;
    logic       r_step_flag;
    logic       w_waiting;
    logic       w_expired;
    logic       w_timer_clear;

    assign w_waiting     = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_timer_clear = (w_next_state != r_state);
    assign ram_addr      = operand;
    assign dbg_state     = r_state;

    seq_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_timer_clear),
        .i_enable  (w_waiting),
        .o_expired (w_expired)
    );

    // Handshakes are only looked at in their own state; the timeout wins a tie.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_HALTED: if (!halt_req && (run || step)) w_next_state = S_FETCH;
            S_FETCH: begin
                if (w_expired)      w_next_state = S_FAULT;
                else if (rom_valid) w_next_state = S_DECODE;
            end
            S_DECODE: begin
                if (opcode[15:0] == HALT_OPCODE)     w_next_state = S_HALTED;
                else if (op_needs_ram(opcode[15:0])) w_next_state = S_MEM;
                else                                 w_next_state = S_EXEC;
            end
            S_MEM: begin
                if (w_expired)    w_next_state = S_FAULT;
                else if (ram_ack) w_next_state = S_EXEC;
            end
            S_EXEC: begin
                if (halt_req || r_step_flag || !run) w_next_state = S_HALTED;
                else                                 w_next_state = S_FETCH;
            end
            S_FAULT: w_next_state = S_FAULT;
            default: w_next_state = S_FAULT;
        endcase
    end

    // Status and strobes are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_HALTED;
            r_step_flag    <= 1'b0;
            halted         <= 1'b1;
            fault          <= 1'b0;
            rom_req        <= 1'b0;
            pc_read_enable <= 1'b0;
            ram_req        <= 1'b0;
            pc_enable      <= 1'b0;
            exec_enable    <= 1'b0;
            opcode         <= '0;
            operand        <= '0;
            mem_data       <= '0;
            instr_count    <= 16'd0;
        end else begin
            r_state        <= w_next_state;
            halted         <= (w_next_state == S_HALTED);
            fault          <= (w_next_state == S_FAULT);
            rom_req        <= (w_next_state == S_FETCH);
            pc_read_enable <= (w_next_state == S_FETCH);
            ram_req        <= (w_next_state == S_MEM);
            pc_enable      <= (w_next_state == S_EXEC);
            exec_enable    <= (w_next_state == S_EXEC);

            if (r_state == S_FETCH && rom_valid && !w_expired) begin
                opcode  <= rom_data[2*DATA_WIDTH-1:DATA_WIDTH];
                operand <= rom_data[DATA_WIDTH-1:0];
            end
            if (r_state == S_MEM && ram_ack && !w_expired) begin
                mem_data <= ram_data;
            end

            // A start from HALTED without run can only be a single step.
            if (r_state == S_HALTED && w_next_state == S_FETCH) begin
                r_step_flag <= !run;
            end else if (r_state == S_EXEC) begin
                r_step_flag <= 1'b0;
            end

            if (r_state == S_EXEC) begin
                instr_count <= instr_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a scoreboard of expected retirements
// checked by a monitor on pc_enable, plus a second instance with a short timeout.
module tb_instr_sequencer;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main DUT
    logic        reset, run, step, halt_req, rom_valid, ram_ack;
    logic [31:0] rom_word;
    logic [15:0] ram_word;
    logic        rom_req, pc_read_enable, ram_req, pc_enable, exec_enable, halted, fault;
    logic [15:0] ram_addr, opcode, operand, mem_data, instr_count;
    seq_state_t  dbg_state;

    instr_sequencer #(.DATA_WIDTH(16), .WAIT_LIMIT(255)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
        .rom_data(rom_word), .rom_valid(rom_valid), .rom_req(rom_req),
        .pc_read_enable(pc_read_enable), .ram_req(ram_req), .ram_addr(ram_addr),
        .ram_ack(ram_ack), .ram_data(ram_word), .opcode(opcode), .operand(operand),
        .mem_data(mem_data), .pc_enable(pc_enable), .exec_enable(exec_enable),
        .halted(halted), .fault(fault), .instr_count(instr_count), .dbg_state(dbg_state)
    );

    // Timeout DUT
    logic        f_reset, f_run, f_rom_valid, f_zero;
    logic [31:0] f_rom_word;
    logic [15:0] f_ram_word;
    logic        f_rom_req, f_pc_read_enable, f_ram_req, f_pc_enable, f_exec_enable, f_halted, f_fault;
    logic [15:0] f_ram_addr, f_opcode, f_operand, f_mem_data, f_instr_count;
    seq_state_t  f_dbg_state;

    instr_sequencer #(.DATA_WIDTH(16), .WAIT_LIMIT(4)) dut_f (
        .clk(clk), .reset(f_reset), .run(f_run), .step(f_zero), .halt_req(f_zero),
        .rom_data(f_rom_word), .rom_valid(f_rom_valid), .rom_req(f_rom_req),
        .pc_read_enable(f_pc_read_enable), .ram_req(f_ram_req), .ram_addr(f_ram_addr),
        .ram_ack(f_zero), .ram_data(f_ram_word), .opcode(f_opcode), .operand(f_operand),
        .mem_data(f_mem_data), .pc_enable(f_pc_enable), .exec_enable(f_exec_enable),
        .halted(f_halted), .fault(f_fault), .instr_count(f_instr_count), .dbg_state(f_dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ROM/RAM responders: assert the handshake after a programmable number of wait cycles.
    int rom_wait = 0, rom_cnt = 0, ram_wait = 0, ram_cnt = 0;
    always @(negedge clk) begin
        if (rom_req) begin
            rom_valid = (rom_cnt >= rom_wait);
            rom_cnt++;
        end else begin
            rom_valid = 1'b0;
            rom_cnt   = 0;
        end
        if (ram_req) begin
            ram_ack = (ram_cnt >= ram_wait);
            ram_cnt++;
        end else begin
            ram_ack = 1'b0;
            ram_cnt = 0;
        end
    end

    // Scoreboard entry: {expected cycle, opcode, mem_data, instr_count before increment}
    logic [63:0] exp_q[$];
    logic [15:0] exp_count = 16'd0;
    logic [15:0] exp_ram_addr = 16'd0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (pc_enable) begin
            chk("exec_enable_with_pc", {31'd0, exec_enable}, 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pc_enable: got pulse expected none (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_cycle", {16'd0, cyc[15:0]}, {16'd0, e[63:48]});
                chk("pulse_opcode", {16'd0, opcode}, {16'd0, e[47:32]});
                chk("pulse_mem_data", {16'd0, mem_data}, {16'd0, e[31:16]});
                chk("pulse_count", {16'd0, instr_count}, {16'd0, e[15:0]});
            end
        end
        if (ram_req) chk("ram_addr", {16'd0, ram_addr}, {16'd0, exp_ram_addr});
    end

    task automatic expect_pulse(input int at, input logic [15:0] op, input logic [15:0] mem);
        exp_q.push_back({16'(at), op, mem, exp_count});
        exp_count = exp_count + 16'd1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_count = 16'd0;
    endtask

    // Run n back-to-back instructions of fixed latency, dropping run during the last EXEC.
    task automatic run_instrs(input int n, input int lat, input logic [15:0] op, input logic [15:0] mem);
        int base;
        base = cyc;
        for (int i = 1; i <= n; i++) expect_pulse(base + i * lat, op, mem);
        run = 1'b1;
        repeat (n * lat) @(negedge clk);
        run = 1'b0;
    endtask

    initial begin
        int base;
        reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
        rom_word = 32'd0; ram_word = 16'd0; rom_valid = 1'b0; ram_ack = 1'b0;
        f_reset = 1'b1; f_run = 1'b0; f_rom_valid = 1'b0; f_zero = 1'b0;
        f_rom_word = {16'h1000, 16'h0001}; f_ram_word = 16'd0;
        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst_halted", {31'd0, halted}, 32'd1);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_rom_req", {31'd0, rom_req}, 32'd0);
        chk("rst_pc_read_enable", {31'd0, pc_read_enable}, 32'd0);
        chk("rst_ram_req", {31'd0, ram_req}, 32'd0);
        chk("rst_pc_enable", {31'd0, pc_enable}, 32'd0);
        chk("rst_instr_count", {16'd0, instr_count}, 32'd0);
        chk("rst_opcode", {16'd0, opcode}, 32'd0);

        // Back-to-back non-RAM instructions: pulses at cycles 3, 6, 9
        rom_word = {16'h1000, 16'h0005}; rom_wait = 0; ram_wait = 0;
        run_instrs(3, 3, 16'h1000, 16'h0000);
        @(negedge clk);
        chk("t1_count", {16'd0, instr_count}, 32'd3);
        chk("t1_operand", {16'd0, operand}, 32'h0005);
        chk("t1_halted", {31'd0, halted}, 32'd1);

        // RAM-source instruction with two RAM wait states: pulse at cycle 6
        rom_word = {16'h7000, 16'h0040}; ram_wait = 2; ram_word = 16'h1234; exp_ram_addr = 16'h0040;
        run_instrs(1, 6, 16'h7000, 16'h1234);
        @(negedge clk);
        chk("t2_mem_data", {16'd0, mem_data}, 32'h1234);
        chk("t2_count", {16'd0, instr_count}, 32'd4);
        chk("t2_halted", {31'd0, halted}, 32'd1);

        // Single step, with a second step pulse during EXEC that must be ignored
        do_reset();
        rom_word = {16'h1000, 16'h0005}; ram_wait = 0;
        base = cyc;
        expect_pulse(base + 3, 16'h1000, 16'h0000);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (2) @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("t3_halted_after_exec", {31'd0, halted}, 32'd1);
        repeat (4) @(negedge clk);
        chk("t3_still_halted", {31'd0, halted}, 32'd1);
        chk("t3_rom_req", {31'd0, rom_req}, 32'd0);
        chk("t3_count", {16'd0, instr_count}, 32'd1);

        // halt_req raised mid-FETCH with three ROM wait states
        rom_word = {16'h2100, 16'h0001}; rom_wait = 3;
        base = cyc;
        expect_pulse(base + 6, 16'h2100, 16'h0000);
        run = 1'b1;
        repeat (2) @(negedge clk);
        halt_req = 1'b1;
        repeat (5) @(negedge clk);
        chk("t4_halted", {31'd0, halted}, 32'd1);
        repeat (3) @(negedge clk);
        chk("t4_halt_over_run", {31'd0, halted}, 32'd1);
        chk("t4_rom_req", {31'd0, rom_req}, 32'd0);
        chk("t4_count", {16'd0, instr_count}, 32'd2);
        halt_req = 1'b0; run = 1'b0;
        @(negedge clk);

        // HALT opcode: returns to HALTED from DECODE without retiring
        rom_word = {16'hFFFF, 16'h0000}; rom_wait = 0;
        run = 1'b1;
        repeat (2) @(negedge clk);
        run = 1'b0;
        chk("t5_decode_not_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        chk("t5_halted", {31'd0, halted}, 32'd1);
        chk("t5_opcode", {16'd0, opcode}, 32'hFFFF);
        chk("t5_count", {16'd0, instr_count}, 32'd2);

        // Reset while waiting in MEM
        rom_word = {16'h3000, 16'h0010}; ram_wait = 1000000; exp_ram_addr = 16'h0010;
        run = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_in_mem", {31'd0, ram_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_ram_req", {31'd0, ram_req}, 32'd0);
        chk("t6_halted", {31'd0, halted}, 32'd1);
        chk("t6_count", {16'd0, instr_count}, 32'd0);
        reset = 1'b0; run = 1'b0; exp_count = 16'd0;

        // Timeout with WAIT_LIMIT=4: a valid on the 4th FETCH cycle loses to the fault
        f_reset = 1'b0; f_run = 1'b1;
        repeat (3) @(negedge clk);
        chk("f_fetch3_fault", {31'd0, f_fault}, 32'd0);
        @(negedge clk);
        chk("f_fetch4_fault", {31'd0, f_fault}, 32'd0);
        chk("f_fetch4_rom_req", {31'd0, f_rom_req}, 32'd1);
        f_rom_valid = 1'b1;
        @(negedge clk);
        f_rom_valid = 1'b0;
        chk("f_fault", {31'd0, f_fault}, 32'd1);
        chk("f_rom_req", {31'd0, f_rom_req}, 32'd0);
        chk("f_halted", {31'd0, f_halted}, 32'd0);
        chk("f_opcode_not_latched", {16'd0, f_opcode}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            f_run = ~f_run;
            @(negedge clk);
        end
        chk("f_fault_sticky", {31'd0, f_fault}, 32'd1);
        chk("f_pc_enable", {31'd0, f_pc_enable}, 32'd0);
        f_reset = 1'b1; f_run = 1'b0;
        @(negedge clk);
        f_reset = 1'b0;
        chk("f_reset_halted", {31'd0, f_halted}, 32'd1);
        chk("f_reset_fault", {31'd0, f_fault}, 32'd0);

        repeat (2) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
